// File: rtl/ctl_ammo.sv
// Gun sequencer shared by the local and remote player: arbitrates triggers,
// counts rounds, and times the post-shot cooldown and the reload.
module ctl_ammo #(
  parameter int AMMO_MAX        = 3,
  parameter int COOLDOWN_CYCLES = 2_000_000,
  parameter int RELOAD_CYCLES   = 40_000_000,
  parameter int AMMO_W          = $clog2(AMMO_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              round_start,
  input  logic              reload,
  input  logic              trig_p1,
  input  logic              trig_p2,
  output logic              shot,
  output logic              shot_player,
  output logic              dry_fire,
  output logic [AMMO_W-1:0] ammo,
  output logic              empty,
  output logic              reloading
);

  localparam int TMAX = (COOLDOWN_CYCLES > RELOAD_CYCLES) ? COOLDOWN_CYCLES : RELOAD_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [AMMO_W-1:0] AMMO_FULL = AMMO_W'(AMMO_MAX);
  localparam logic [TW-1:0]     T_COOL    = TW'(COOLDOWN_CYCLES - 1);
  localparam logic [TW-1:0]     T_RELOAD  = TW'(RELOAD_CYCLES - 1);

  typedef enum logic [1:0] {S_READY, S_COOLDOWN, S_EMPTY, S_RELOAD} state_t;

  state_t            r_state, w_state_next;
  logic [AMMO_W-1:0] r_ammo, w_ammo_next;
  logic [TW-1:0]     r_timer, w_timer_next;
  logic              r_shot, w_shot_next;
  logic              r_shot_player, w_shot_player_next;
  logic              r_dry_fire, w_dry_fire_next;
  logic              r_rr_last, w_rr_last_next;
  logic              r_empty, r_reloading;

  logic w_v1, w_v2, w_any, w_pick;

  assign w_v1  = trig_p1 & enable;
  assign w_v2  = trig_p2 & enable;
  assign w_any = w_v1 | w_v2;
  // On a tie the player who did not win last time gets the gun (0=p1, 1=p2).
  assign w_pick = (w_v1 & w_v2) ? ~r_rr_last : w_v2;

  always_comb begin
    w_state_next       = r_state;
    w_ammo_next        = r_ammo;
    w_timer_next       = r_timer;
    w_shot_next        = 1'b0;
    w_shot_player_next = r_shot_player;
    w_dry_fire_next    = 1'b0;
    w_rr_last_next     = r_rr_last;
    if (round_start) begin
      w_state_next = S_READY;
      w_ammo_next  = AMMO_FULL;
      w_timer_next = '0;
    end else begin
      unique case (r_state)
        S_READY: begin
          if (reload && (r_ammo < AMMO_FULL)) begin
            w_state_next = S_RELOAD;
            w_timer_next = T_RELOAD;
          end else if (w_any && (r_ammo != '0)) begin
            w_shot_next        = 1'b1;
            w_shot_player_next = w_pick;
            w_rr_last_next     = w_pick;
            w_ammo_next        = r_ammo - AMMO_W'(1);
            w_state_next       = S_COOLDOWN;
            w_timer_next       = T_COOL;
          end
        end
        S_COOLDOWN: begin
          if (reload) begin
            w_state_next = S_RELOAD;
            w_timer_next = T_RELOAD;
          end else if (r_timer == '0) begin
            w_state_next = (r_ammo == '0) ? S_EMPTY : S_READY;
          end else begin
            w_timer_next = r_timer - TW'(1);
          end
        end
        S_EMPTY: begin
          if (reload) begin
            w_state_next = S_RELOAD;
            w_timer_next = T_RELOAD;
          end else if (w_any) begin
            w_dry_fire_next = 1'b1;
          end
        end
        S_RELOAD: begin
          if (r_timer == '0) begin
            w_state_next = S_READY;
            w_ammo_next  = AMMO_FULL;
          end else begin
            w_timer_next = r_timer - TW'(1);
          end
        end
        default: w_state_next = S_READY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_READY;
      r_ammo        <= AMMO_FULL;
      r_timer       <= '0;
      r_shot        <= 1'b0;
      r_shot_player <= 1'b0;
      r_dry_fire    <= 1'b0;
      r_rr_last     <= 1'b1;
      r_empty       <= 1'b0;
      r_reloading   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_ammo        <= w_ammo_next;
      r_timer       <= w_timer_next;
      r_shot        <= w_shot_next;
      r_shot_player <= w_shot_player_next;
      r_dry_fire    <= w_dry_fire_next;
      r_rr_last     <= w_rr_last_next;
      // Status flags track the state being entered so they line up with it.
      r_empty       <= (w_state_next == S_EMPTY);
      r_reloading   <= (w_state_next == S_RELOAD);
    end
  end

  assign shot        = r_shot;
  assign shot_player = r_shot_player;
  assign dry_fire    = r_dry_fire;
  assign ammo        = r_ammo;
  assign empty       = r_empty;
  assign reloading   = r_reloading;

endmodule

// File: tb/tb_ctl_ammo.sv
// Directed bench for ctl_ammo with a short cooldown (4) and reload (10).
module tb_ctl_ammo;

  logic       clk, rst_n, enable, round_start, reload, trig_p1, trig_p2;
  logic       shot, shot_player, dry_fire, empty, reloading;
  logic [1:0] ammo;
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_rel;

  ctl_ammo #(.AMMO_MAX(3), .COOLDOWN_CYCLES(4), .RELOAD_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .round_start(round_start),
    .reload(reload), .trig_p1(trig_p1), .trig_p2(trig_p2), .shot(shot),
    .shot_player(shot_player), .dry_fire(dry_fire), .ammo(ammo),
    .empty(empty), .reloading(reloading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_inputs();
    round_start = 1'b0; reload = 1'b0; trig_p1 = 1'b0; trig_p2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1;
    release_inputs();
    tick();
    chk("rst_ammo", ammo, 3);
    chk("rst_shot", shot, 0);
    #2 rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_ammo", ammo, 3);
    chk("idle_shot", shot, 0);
    chk("idle_empty", empty, 0);
    chk("idle_reloading", reloading, 0);
    chk("idle_dry", dry_fire, 0);

    // single shot, dropped trigger in cooldown, next shot after cooldown
    trig_p1 = 1'b1; tick(); release_inputs();
    chk("s1_shot", shot, 1);
    chk("s1_player", shot_player, 0);
    chk("s1_ammo", ammo, 2);
    tick();
    chk("s1_pulse_end", shot, 0);
    tick();
    trig_p1 = 1'b1; tick(); release_inputs();
    chk("cool_drop_shot", shot, 0);
    chk("cool_drop_ammo", ammo, 2);
    tick();
    trig_p1 = 1'b1; tick(); release_inputs();
    chk("s2_shot", shot, 1);
    chk("s2_ammo", ammo, 1);

    // fresh reset so rr_last starts at p2 (p1 wins first tie)
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    trig_p1 = 1'b1; trig_p2 = 1'b1; tick(); release_inputs();
    chk("tie1_player", shot_player, 0);
    chk("tie1_ammo", ammo, 2);
    repeat (4) tick();
    trig_p1 = 1'b1; trig_p2 = 1'b1; tick(); release_inputs();
    chk("tie2_shot", shot, 1);
    chk("tie2_player", shot_player, 1);
    repeat (4) tick();
    trig_p1 = 1'b1; trig_p2 = 1'b1; tick(); release_inputs();
    chk("tie3_player", shot_player, 0);
    chk("tie3_ammo", ammo, 0);

    // magazine empty after third cooldown, dry fire, full reload
    repeat (3) tick();
    chk("pre_empty", empty, 0);
    tick();
    chk("empty", empty, 1);
    trig_p2 = 1'b1; tick(); release_inputs();
    chk("dry_pulse", dry_fire, 1);
    chk("dry_no_shot", shot, 0);
    chk("dry_ammo", ammo, 0);
    chk("dry_player_held", shot_player, 0);
    tick();
    chk("dry_pulse_end", dry_fire, 0);
    reload = 1'b1; tick(); release_inputs();
    chk("rel_enter", reloading, 1);
    chk("rel_empty_clr", empty, 0);
    n_rel = 1;
    trig_p1 = 1'b1; reload = 1'b1; tick(); release_inputs();
    chk("rel_trig_ignored", shot, 0);
    if (reloading) n_rel++;
    while (reloading === 1'b1 && n_rel < 20) begin
      tick();
      if (reloading) n_rel++;
    end
    chk("rel_cycles", n_rel, 10);
    chk("rel_done_ammo", ammo, 3);

    // reload beats trigger; round_start aborts reload
    trig_p1 = 1'b1; tick(); release_inputs();
    chk("s5_shot", shot, 1);
    chk("s5_player", shot_player, 0);
    repeat (4) tick();
    reload = 1'b1; trig_p1 = 1'b1; tick(); release_inputs();
    chk("rel_vs_trig_shot", shot, 0);
    chk("rel_vs_trig_rel", reloading, 1);
    chk("rel_vs_trig_ammo", ammo, 2);
    repeat (4) tick();
    round_start = 1'b1; tick(); release_inputs();
    chk("rs_reloading", reloading, 0);
    chk("rs_ammo", ammo, 3);
    trig_p1 = 1'b1; tick(); release_inputs();
    chk("rs_shot", shot, 1);
    chk("rs_shot_ammo", ammo, 2);
    round_start = 1'b1; tick(); release_inputs();
    chk("rs2_ammo", ammo, 3);
    reload = 1'b1; trig_p2 = 1'b1; tick(); release_inputs();
    chk("full_rel_ignored", reloading, 0);
    chk("full_rel_shot", shot, 1);
    chk("full_rel_player", shot_player, 1);
    chk("full_rel_ammo", ammo, 2);

    // enable low masks triggers
    repeat (4) tick();
    enable = 1'b0;
    trig_p1 = 1'b1; tick(); release_inputs();
    chk("dis_shot1", shot, 0);
    trig_p2 = 1'b1; tick(); release_inputs();
    chk("dis_shot2", shot, 0);
    chk("dis_ammo", ammo, 2);
    enable = 1'b1;

    // async reset mid-cooldown, between edges
    trig_p2 = 1'b1; tick(); release_inputs();
    chk("pre_rst_shot", shot, 1);
    chk("pre_rst_player", shot_player, 1);
    chk("pre_rst_ammo", ammo, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_shot", shot, 0);
    chk("async_player", shot_player, 0);
    chk("async_ammo", ammo, 3);
    chk("async_reloading", reloading, 0);
    #2 rst_n = 1'b1;
    trig_p1 = 1'b1; trig_p2 = 1'b1; tick(); release_inputs();
    chk("post_rst_shot", shot, 1);
    chk("post_rst_player", shot_player, 0);
    chk("post_rst_ammo", ammo, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
